// File: rtl/bus_slave_regs.sv
// -----------------------------------------------------------------------------
// bus_slave_regs
//   Slave end of the CPU bus. It holds a bank of 2**ADDR_W 32-bit read/write
//   registers and answers each selected access after WAIT_CYCLES wait states.
//   The answer is a one-cycle active-low ready pulse with read data.
//   Outside the acknowledge cycle rd_data is zero, so several slaves can share
//   the bus through an OR.
//
//   Ports
//     i_clk      in   1       system clock, rising edge
//     i_reset_   in   1       asynchronous reset, active-low
//     i_cs_      in   1       chip select, active-low
//     i_as_      in   1       address strobe, active-low
//     i_rw       in   1       1 = read, 0 = write
//     i_addr     in   ADDR_W  word index
//     i_wr_data  in   32      write data
//     o_rd_data  out  32      read data, valid only while o_rdy_ = 0, else 0
//     o_rdy_     out  1       acknowledge, active-low, one cycle per access
//     o_busy     out  1       high while in WAIT or ACK
// -----------------------------------------------------------------------------
module bus_slave_regs #(
    parameter int          ADDR_W      = 3,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] RESET_VAL   = 32'h0
) (
    input  logic              i_clk,
    input  logic              i_reset_,
    input  logic              i_cs_,
    input  logic              i_as_,
    input  logic              i_rw,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wr_data,
    output logic [31:0]       o_rd_data,
    output logic              o_rdy_,
    output logic              o_busy
);

    localparam int         NREG      = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic [31:0]       r_wr_data;
    logic [31:0]       r_rd_data;
    logic [31:0]       r_regs [NREG];

    logic              w_req;
    logic              w_enter_ack;
    logic [ADDR_W-1:0] w_acc_addr;
    logic              w_acc_rw;
    logic [31:0]       w_acc_wr_data;
    logic [NREG-1:0]   w_we;

    assign w_req = ~i_cs_ & ~i_as_;

    // With zero wait states ACK is entered on the sampling edge itself, before
    // the latches hold anything, so the access is taken straight from the bus.
    assign w_acc_addr    = (r_state == ST_IDLE) ? i_addr    : r_addr;
    assign w_acc_rw      = (r_state == ST_IDLE) ? i_rw      : r_rw;
    assign w_acc_wr_data = (r_state == ST_IDLE) ? i_wr_data : r_wr_data;

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_enter_ack  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_cnt_next = WAIT_INIT;
                    if (WAIT_INIT == 4'd0) begin
                        w_state_next = ST_ACK;
                        w_enter_ack  = 1'b1;
                    end else begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!w_req) begin
                    // Master withdrew the access: drop it without a write or rdy_.
                    w_state_next = ST_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_state_next = ST_ACK;
                    w_enter_ack  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_ACK: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, counter, access latches and the registered read data
    always_ff @(posedge i_clk or negedge i_reset_) begin
        if (!i_reset_) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= '0;
            r_rw      <= 1'b0;
            r_wr_data <= 32'h0;
            r_rd_data <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (r_state == ST_IDLE && w_req) begin
                r_addr    <= i_addr;
                r_rw      <= i_rw;
                r_wr_data <= i_wr_data;
            end
            // ACK always lasts a single cycle, so the data register is non-zero
            // only in the cycle that follows entry into ACK.
            r_rd_data <= (w_enter_ack && w_acc_rw) ? r_regs[w_acc_addr] : 32'h0;
        end
    end

    // One write-enable per register (full decode)
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_we
            assign w_we[gi] = w_enter_ack & ~w_acc_rw & (w_acc_addr == ADDR_W'(gi));
        end
    endgenerate

    // Register bank. It is reset as a whole, so it is built from flops rather than RAM.
    always_ff @(posedge i_clk or negedge i_reset_) begin
        if (!i_reset_) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_we[i]) begin
                    r_regs[i] <= w_acc_wr_data;
                end
            end
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_rdy_    = (r_state != ST_ACK);
    assign o_busy    = (r_state != ST_IDLE);

endmodule
